mem_req_arbiter: RTL

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter_pkg.sv | 22 ++
 rtl/mem_req_arbiter_if.sv | 21 ++
 rtl/mem_req_arbiter_rr_pick.sv | 33 +++
 rtl/mem_req_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared encodings for the memory request arbiter: FSM states, access sizes
// and a helper for sizing channel-index fields.
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef logic [1:0] size_t;

  localparam size_t SZ_BYTE = 2'd0;
  localparam size_t SZ_HALF = 2'd1;
  localparam size_t SZ_WORD = 2'd2;

  // A single channel still needs a 1-bit index field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Memory-side request bus: one outstanding transaction, split address and
// data handshakes.
interface mem_req_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  import mem_req_arbiter_pkg::*;

  logic          req;
  logic          wr;
  size_t         size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          addr_ok;
  logic          data_ok;
  logic [DW-1:0] rdata;

  modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);

endinterface

// File: rtl/mem_req_arbiter_rr_pick.sv
// Request picker: fixed priority (lowest index) or round-robin starting just
// after the last granted index. Produces one-hot grant and its index.
module rr_pick #(
  parameter int NCH = 2,
  parameter int RR  = 1,
  parameter int IW  = 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  last,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx
);

  logic          found;
  logic [IW-1:0] ci;

  always_comb begin
    found = 1'b0;
    ci    = '0;
    gnt   = '0;
    idx   = '0;
    // Scan candidates in priority order; the first requester wins.
    for (int k = 0; k < NCH; k++) begin
      ci = (RR != 0) ? IW'((int'(last) + 1 + k) % NCH) : IW'(k);
      if (!found && req[ci]) begin
        found = 1'b1;
        idx   = ci;
      end
    end
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Multi-channel memory request arbiter: picks one requester, forwards it to
// the memory bus, and routes the address/data handshakes back to it.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int RR  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          ch_req,
  input  logic [NCH-1:0]          ch_wr,
  input  size_t [NCH-1:0]         ch_size,
  input  logic [NCH-1:0][AW-1:0]  ch_addr,
  input  logic [NCH-1:0][DW-1:0]  ch_wdata,
  output logic [NCH-1:0]          ch_addr_ok,
  output logic [NCH-1:0]          ch_data_ok,
  output logic [DW-1:0]           ch_rdata,
  output logic [NCH-1:0]          ch_stall,
  output logic                    longest_stall,
  mem_req_arbiter_if.master       mem
);

  localparam int IW = idx_w(NCH);

  state_t         state, nxt;
  logic [NCH-1:0] gnt, pick_gnt, inflight;
  logic [IW-1:0]  last, pick_idx;
  logic           wr_q;
  size_t          size_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic           start;

  assign start = (state == IDLE) && (|ch_req);

  rr_pick #(.NCH(NCH), .RR(RR), .IW(IW)) u_pick (
    .req  (ch_req),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Pointer resets to the top index so channel 0 wins the first round.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= '0;
      last    <= IW'(NCH - 1);
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start) begin
      gnt     <= pick_gnt;
      last    <= pick_idx;
      wr_q    <= ch_wr[pick_idx];
      size_q  <= ch_size[pick_idx];
      addr_q  <= ch_addr[pick_idx];
      wdata_q <= ch_wdata[pick_idx];
    end
  end

  assign mem.wr    = wr_q;
  assign mem.size  = size_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;

  always_comb begin
    nxt        = state;
    mem.req    = 1'b0;
    ch_addr_ok = '0;
    ch_data_ok = '0;
    ch_rdata   = '0;
    inflight   = '0;
    case (state)
      IDLE: if (|ch_req) nxt = ADDR;
      ADDR: begin
        mem.req  = 1'b1;
        inflight = gnt;
        if (mem.addr_ok) begin
          ch_addr_ok = gnt;
          nxt        = DATA;
        end
      end
      DATA: begin
        // The completing cycle no longer counts the owner as stalled.
        if (mem.data_ok) begin
          ch_data_ok = gnt;
          ch_rdata   = mem.rdata;
          nxt        = IDLE;
        end else begin
          inflight = gnt;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign ch_stall      = ch_req | inflight;
  assign longest_stall = |ch_stall;

endmodule
